// File: rtl/axi_lite_pkg.sv
// ----------------------------------------------------------------------------
// axi_lite_pkg : shared widths, response codes and master FSM state encoding
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package axi_lite_pkg;

  localparam int AXIL_ADDR_WIDTH  = 32;
  localparam int AXIL_DATA_WIDTH  = 32;
  localparam int AXIL_RDATA_WIDTH = 8;
  localparam int AXIL_RESP_WIDTH  = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } axil_state_e;

endpackage

`default_nettype wire

// File: rtl/axi_lite_watchdog.sv
// ----------------------------------------------------------------------------
// axi_lite_watchdog : per-phase cycle counter, expires after TIMEOUT_CYCLES
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axi_lite_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      assign expired_o = 1'b0;
    end else begin : g_enabled
      localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      logic [CW-1:0] cnt_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          cnt_q <= '0;
        end else if (clear_i) begin
          cnt_q <= '0;
        end else if (en_i) begin
          cnt_q <= cnt_q + CW'(1);
        end
      end

      // Fires during the TIMEOUT_CYCLES-th cycle spent in the waiting state.
      assign expired_o = en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/axi_lite_master.sv
// ----------------------------------------------------------------------------
// axi_lite_master : single-outstanding AXI4-Lite initiator with watchdog abort
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = AXIL_ADDR_WIDTH,
  parameter int DATA_WIDTH     = AXIL_DATA_WIDTH,
  parameter int RDATA_WIDTH    = AXIL_RDATA_WIDTH,
  parameter int RESP_WIDTH     = AXIL_RESP_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   CMD_VALID,
  output logic                   CMD_READY,
  input  logic                   CMD_RNW,
  input  logic [ADDR_WIDTH-1:0]  CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]  CMD_WDATA,
  output logic                   RSP_VALID,
  input  logic                   RSP_READY,
  output logic                   RSP_RNW,
  output logic [RESP_WIDTH-1:0]  RSP_RESP,
  output logic [RDATA_WIDTH-1:0] RSP_RDATA,
  output logic                   RSP_TIMEOUT,
  output logic                   AWVALID,
  input  logic                   AWREADY,
  output logic [ADDR_WIDTH-1:0]  AWADDR,
  output logic                   WVALID,
  input  logic                   WREADY,
  output logic [DATA_WIDTH-1:0]  WDATA,
  input  logic                   BVALID,
  output logic                   BREADY,
  input  logic [RESP_WIDTH-1:0]  BRESP,
  output logic                   ARVALID,
  input  logic                   ARREADY,
  output logic [ADDR_WIDTH-1:0]  ARADDR,
  input  logic                   RVALID,
  output logic                   RREADY,
  input  logic [RDATA_WIDTH-1:0] RDATA,
  input  logic [RESP_WIDTH-1:0]  RRESP
);

  axil_state_e            state_q, state_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   awvalid_q, awvalid_d;
  logic                   wvalid_q, wvalid_d;
  logic                   bready_q, bready_d;
  logic                   arvalid_q, arvalid_d;
  logic                   rready_q, rready_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_rnw_q, rsp_rnw_d;
  logic [RESP_WIDTH-1:0]  rsp_resp_q, rsp_resp_d;
  logic [RDATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_timeout_q, rsp_timeout_d;

  logic w_wd_clear, w_wd_en, w_wd_expired;
  logic w_aw_done, w_w_done;

  assign w_wd_en    = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                      (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);
  assign w_wd_clear = (state_d != state_q);

  axi_lite_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (ACLK),
    .rst_i    (ARESET),
    .clear_i  (w_wd_clear),
    .en_i     (w_wd_en),
    .expired_o(w_wd_expired)
  );

  // A channel is done once its VALID is low or it handshakes this cycle.
  assign w_aw_done = !awvalid_q || AWREADY;
  assign w_w_done  = !wvalid_q  || WREADY;

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rnw_d     = rsp_rnw_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = CMD_ADDR;
          wdata_d     = CMD_WDATA;
          rsp_rnw_d   = CMD_RNW;
          if (CMD_RNW) begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_REQ;
          end else begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        if (awvalid_q && AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
        if (w_aw_done && w_w_done) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end else if (w_wd_expired) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          state_d   = ST_RSP;
        end
      end
      ST_WR_RESP: begin
        if (BVALID && bready_q) begin
          bready_d = 1'b0;
          state_d  = ST_RSP;
        end else if (w_wd_expired) begin
          bready_d = 1'b0;
          state_d  = ST_RSP;
        end
      end
      ST_RD_REQ: begin
        if (arvalid_q && ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end else if (w_wd_expired) begin
          arvalid_d = 1'b0;
          state_d   = ST_RSP;
        end
      end
      ST_RD_DATA: begin
        if (RVALID && rready_q) begin
          rready_d = 1'b0;
          state_d  = ST_RSP;
        end else if (w_wd_expired) begin
          rready_d = 1'b0;
          state_d  = ST_RSP;
        end
      end
      ST_RSP: begin
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Response payload is loaded on the single transition into RSP.
    if (state_d == ST_RSP && state_q != ST_RSP) begin
      rsp_valid_d = 1'b1;
      if ((state_q == ST_WR_RESP) && BVALID && bready_q) begin
        rsp_resp_d    = BRESP;
        rsp_rdata_d   = '0;
        rsp_timeout_d = 1'b0;
      end else if ((state_q == ST_RD_DATA) && RVALID && rready_q) begin
        rsp_resp_d    = RRESP;
        rsp_rdata_d   = RDATA;
        rsp_timeout_d = 1'b0;
      end else begin
        rsp_resp_d    = RESP_WIDTH'(RESP_SLVERR);
        rsp_rdata_d   = '0;
        rsp_timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b1;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rnw_q     <= 1'b0;
      rsp_resp_q    <= '0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rnw_q     <= rsp_rnw_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign CMD_READY   = cmd_ready_q;
  assign AWVALID     = awvalid_q;
  assign AWADDR      = addr_q;
  assign WVALID      = wvalid_q;
  assign WDATA       = wdata_q;
  assign BREADY      = bready_q;
  assign ARVALID     = arvalid_q;
  assign ARADDR      = addr_q;
  assign RREADY      = rready_q;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_RNW     = rsp_rnw_q;
  assign RSP_RESP    = rsp_resp_q;
  assign RSP_RDATA   = rsp_rdata_q;
  assign RSP_TIMEOUT = rsp_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_master.sv
// ----------------------------------------------------------------------------
// tb_axi_lite_master : directed self-checking bench for axi_lite_master
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_rnw = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        awready = 1'b0;
  logic        wready = 1'b0;
  logic        bvalid = 1'b0;
  logic [1:0]  bresp = '0;
  logic        arready = 1'b0;
  logic        rvalid = 1'b0;
  logic [7:0]  rdata = '0;
  logic [1:0]  rresp = '0;

  logic        cmd_ready, rsp_valid, rsp_rnw, rsp_timeout;
  logic [1:0]  rsp_resp;
  logic [7:0]  rsp_rdata;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] awaddr, wdata, araddr;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_lite_master #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .ACLK(clk), .ARESET(rst),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_RNW(cmd_rnw),
    .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RNW(rsp_rnw),
    .RSP_RESP(rsp_resp), .RSP_RDATA(rsp_rdata), .RSP_TIMEOUT(rsp_timeout),
    .AWVALID(awvalid), .AWREADY(awready), .AWADDR(awaddr),
    .WVALID(wvalid), .WREADY(wready), .WDATA(wdata),
    .BVALID(bvalid), .BREADY(bready), .BRESP(bresp),
    .ARVALID(arvalid), .ARREADY(arready), .ARADDR(araddr),
    .RVALID(rvalid), .RREADY(rready), .RDATA(rdata), .RRESP(rresp)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic rnw, input logic [31:0] addr, input logic [31:0] wd);
    cmd_valid = 1'b1;
    cmd_rnw   = rnw;
    cmd_addr  = addr;
    cmd_wdata = wd;
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic consume_rsp();
    rsp_ready = 1'b1;
    step(1);
    rsp_ready = 1'b0;
    check("rsp_done_valid", 32'(rsp_valid), 32'd0);
    check("rsp_done_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    // Reset state
    step(2);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_awvalid", 32'(awvalid), 32'd0);
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_bready", 32'(bready), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_fields", {27'd0, rsp_timeout, rsp_rnw, rsp_resp, 1'b0}, 32'd0);
    rst = 1'b0;
    step(1);

    // 1: minimum-latency write
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    send_cmd(1'b0, 32'h1234_0001, 32'h1);
    check("t1_awvalid", 32'(awvalid), 32'd1);
    check("t1_wvalid", 32'(wvalid), 32'd1);
    check("t1_awaddr", awaddr, 32'h1234_0001);
    check("t1_wdata", wdata, 32'h1);
    check("t1_cmd_ready", 32'(cmd_ready), 32'd0);
    step(1);
    check("t1_aw_drop", 32'(awvalid), 32'd0);
    check("t1_bready", 32'(bready), 32'd1);
    check("t1_rsp_early", 32'(rsp_valid), 32'd0);
    step(1);
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rsp_resp", 32'(rsp_resp), 32'd0);
    check("t1_rsp_rnw", 32'(rsp_rnw), 32'd0);
    check("t1_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("t1_bready_drop", 32'(bready), 32'd0);
    consume_rsp();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

    // 2: W accepted three cycles before AW
    wready = 1'b1;
    send_cmd(1'b0, 32'h1234_AA1D, 32'h2);
    step(1);
    wready = 1'b0;
    check("t2_wvalid_drop", 32'(wvalid), 32'd0);
    check("t2_awvalid_hold", 32'(awvalid), 32'd1);
    step(1);
    check("t2_awaddr_hold", awaddr, 32'h1234_AA1D);
    check("t2_bready_wait", 32'(bready), 32'd0);
    step(1);
    check("t2_awvalid_hold2", 32'(awvalid), 32'd1);
    awready = 1'b1;
    step(1);
    awready = 1'b0;
    check("t2_awvalid_drop", 32'(awvalid), 32'd0);
    check("t2_bready", 32'(bready), 32'd1);
    bvalid = 1'b1; bresp = 2'b00;
    step(1);
    bvalid = 1'b0;
    check("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t2_rsp_resp", 32'(rsp_resp), 32'd0);
    consume_rsp();

    // 3: read, ARREADY after two cycles
    send_cmd(1'b1, 32'h0000_0002, 32'h0);
    check("t3_arvalid", 32'(arvalid), 32'd1);
    check("t3_araddr", araddr, 32'h2);
    check("t3_awvalid", 32'(awvalid), 32'd0);
    step(1);
    check("t3_arvalid_hold", 32'(arvalid), 32'd1);
    arready = 1'b1;
    step(1);
    arready = 1'b0;
    check("t3_arvalid_drop", 32'(arvalid), 32'd0);
    check("t3_rready", 32'(rready), 32'd1);
    rvalid = 1'b1; rdata = 8'h0A; rresp = 2'b00;
    step(1);
    rvalid = 1'b0;
    check("t3_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t3_rsp_rdata", 32'(rsp_rdata), 32'h0A);
    check("t3_rsp_rnw", 32'(rsp_rnw), 32'd1);
    check("t3_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("t3_rready_drop", 32'(rready), 32'd0);
    consume_rsp();

    // 4: ARREADY stuck low, watchdog of 8 cycles
    send_cmd(1'b1, 32'h0000_0040, 32'h0);
    step(7);
    check("t4_arvalid_c8", 32'(arvalid), 32'd1);
    check("t4_rsp_early", 32'(rsp_valid), 32'd0);
    step(1);
    check("t4_arvalid_drop", 32'(arvalid), 32'd0);
    check("t4_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t4_rsp_timeout", 32'(rsp_timeout), 32'd1);
    check("t4_rsp_resp", 32'(rsp_resp), 32'd2);
    check("t4_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("t4_rready", 32'(rready), 32'd0);
    consume_rsp();

    // 5: response back-pressure with DECERR
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b11;
    send_cmd(1'b0, 32'h0000_1000, 32'h55);
    step(2);
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t5_rsp_valid", 32'(rsp_valid), 32'd1);
      check("t5_rsp_resp", 32'(rsp_resp), 32'd3);
      check("t5_cmd_ready", 32'(cmd_ready), 32'd0);
      step(1);
    end
    check("t5_rsp_timeout", 32'(rsp_timeout), 32'd0);
    consume_rsp();

    // 6: asynchronous reset while AWVALID is high
    send_cmd(1'b0, 32'h0000_2000, 32'h77);
    check("t6_awvalid_pre", 32'(awvalid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_awvalid_async", 32'(awvalid), 32'd0);
    check("t6_wvalid_async", 32'(wvalid), 32'd0);
    check("t6_cmd_ready_async", 32'(cmd_ready), 32'd1);
    step(1);
    rst = 1'b0;
    step(2);
    check("t6_no_rsp", 32'(rsp_valid), 32'd0);
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    send_cmd(1'b0, 32'h0000_3000, 32'h99);
    check("t6_awaddr", awaddr, 32'h0000_3000);
    step(2);
    check("t6_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t6_rsp_resp", 32'(rsp_resp), 32'd0);
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    consume_rsp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
